// File: rtl/cpu_fetch.sv
// Instruction fetch unit for the moxie core.
// Reads 16-bit halfwords from instruction memory over a read/ack handshake,
// assembles opcode + 32-bit immediate for long opcodes, presents the result
// to decode (honouring stall_i), and redirects on branch_flag_i, discarding
// any fetch that was already in flight.
// Optional feature: define MOXIE_FETCH_PREFETCH_EN to prefetch one halfword
// while an instruction is being presented.
//
// Memory handshake: imem_read_o and imem_address_o stay constant from the
// cycle the request is raised until the cycle imem_ack_i=1; imem_data_i is
// sampled in that cycle; an ack while imem_read_o=0 is ignored.
// Decode handshake: an instruction is consumed on a cycle with valid_o=1 and
// stall_i=0; a redirect in that cycle wins and nothing is consumed.
module cpu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_address_o,
  output logic        imem_read_o,
  input  logic [15:0] imem_data_i,
  input  logic        imem_ack_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_i,
  output logic [15:0] opcode_o,
  output logic [31:0] operand_o,
  output logic        valid_o,
  output logic [31:0] pc_o
);

  // DRAIN waits out a request that was in flight when a redirect arrived.
  typedef enum logic [2:0] {
    FETCH_OP = 3'd0,
    FETCH_HI = 3'd1,
    FETCH_LO = 3'd2,
    PRESENT  = 3'd3,
    DRAIN    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] op_pc_q, op_pc_d;
  logic [15:0] opcode_q, opcode_d;
  logic [31:0] operand_q, operand_d;
  logic        run_q;
  logic        req;
  logic        ack;

`ifdef MOXIE_FETCH_PREFETCH_EN
  logic        hold_valid_q, hold_valid_d;
  logic [15:0] hold_data_q, hold_data_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic [15:0] next_hw;
  logic [31:0] next_addr;
`endif

  // Opcodes whose high byte is in this set carry a 32-bit immediate.
  function automatic logic is_long(input logic [15:0] op);
    case (op[15:8])
      8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
      8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39: is_long = 1'b1;
      default: is_long = 1'b0;
    endcase
  endfunction

  // Request generation: fetch states always request; PRESENT only prefetches.
  always_comb begin
    req = 1'b0;
    if (run_q) begin
      case (state_q)
        FETCH_OP, FETCH_HI, FETCH_LO, DRAIN: req = 1'b1;
`ifdef MOXIE_FETCH_PREFETCH_EN
        PRESENT: req = !hold_valid_q;
`endif
        default: req = 1'b0;
      endcase
    end
  end

  assign ack            = imem_ack_i & req;
  assign imem_read_o    = req;
  assign imem_address_o = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign valid_o        = (state_q == PRESENT);
  assign opcode_o       = opcode_q;
  assign operand_o      = operand_q;
  assign pc_o           = op_pc_q;

  // Next-state logic; a redirect overrides everything at the end.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    op_pc_d      = op_pc_q;
    opcode_d     = opcode_q;
    operand_d    = operand_q;
`ifdef MOXIE_FETCH_PREFETCH_EN
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_addr_d  = hold_addr_q;
    next_hw      = hold_valid_q ? hold_data_q : imem_data_i;
    next_addr    = hold_valid_q ? hold_addr_q : pc_q;
`endif

    case (state_q)
      FETCH_OP: begin
        if (ack) begin
          opcode_d  = imem_data_i;
          operand_d = 32'd0;
          op_pc_d   = pc_q;
          pc_d      = pc_q + 32'd2;
          state_d   = is_long(imem_data_i) ? FETCH_HI : PRESENT;
        end
      end
      FETCH_HI: begin
        if (ack) begin
          operand_d[31:16] = imem_data_i;
          pc_d             = pc_q + 32'd2;
          state_d          = FETCH_LO;
        end
      end
      FETCH_LO: begin
        if (ack) begin
          operand_d[15:0] = imem_data_i;
          pc_d            = pc_q + 32'd2;
          state_d         = PRESENT;
        end
      end
      PRESENT: begin
`ifdef MOXIE_FETCH_PREFETCH_EN
        if (ack) begin
          hold_valid_d = 1'b1;
          hold_data_d  = imem_data_i;
          hold_addr_d  = pc_q;
          pc_d         = pc_q + 32'd2;
        end
`endif
        if (!stall_i) begin
          state_d = FETCH_OP;
`ifdef MOXIE_FETCH_PREFETCH_EN
          // A halfword already in hand becomes the next opcode without
          // spending a FETCH_OP cycle.
          if (hold_valid_q || ack) begin
            opcode_d     = next_hw;
            operand_d    = 32'd0;
            op_pc_d      = next_addr;
            hold_valid_d = 1'b0;
            state_d      = is_long(next_hw) ? FETCH_HI : PRESENT;
          end
`endif
        end
      end
      DRAIN: begin
        if (ack) state_d = FETCH_OP;
      end
      default: state_d = FETCH_OP;
    endcase

    if (branch_flag_i) begin
      pc_d         = branch_target_i & ~32'd1;
      drain_addr_d = imem_address_o;
      state_d      = (req && !imem_ack_i) ? DRAIN : FETCH_OP;
`ifdef MOXIE_FETCH_PREFETCH_EN
      hold_valid_d = 1'b0;
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= FETCH_OP;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      op_pc_q      <= RESET_PC;
      opcode_q     <= 16'd0;
      operand_q    <= 32'd0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      op_pc_q      <= op_pc_d;
      opcode_q     <= opcode_d;
      operand_q    <= operand_d;
      run_q        <= 1'b1;
    end
  end

`ifdef MOXIE_FETCH_PREFETCH_EN
  // One-entry prefetch holding register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= 16'd0;
      hold_addr_q  <= 32'd0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_addr_q  <= hold_addr_d;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch: randomized memory latency, stalls and
// redirects against an instruction-stream reference model, plus directed
// cases for reset, long-opcode assembly, stall hold, redirect and throughput.
module tb_cpu_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_1000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] imem_address_o;
  logic        imem_read_o;
  logic [15:0] imem_data_i = 16'd0;
  logic        imem_ack_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'd0;
  logic        stall_i = 1'b0;
  logic [15:0] opcode_o;
  logic [31:0] operand_o;
  logic        valid_o;
  logic [31:0] pc_o;

  cpu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_address_o(imem_address_o), .imem_read_o(imem_read_o),
    .imem_data_i(imem_data_i), .imem_ack_i(imem_ack_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .stall_i(stall_i), .opcode_o(opcode_o), .operand_o(operand_o),
    .valid_o(valid_o), .pc_o(pc_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- counters / checker ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  // ---------------- memory + reference model ----------------
  logic [7:0]  long_ops [17] = '{8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B,
                                 8'h1D, 8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39};
  logic [15:0] mem [logic [31:0]];
  logic [31:0] model_pc;
  logic [79:0] exp_q[$];     // {pc, opcode, operand}
  logic [31:0] rd_log[$];    // addresses of acked reads since reset

  function automatic logic [15:0] mem_rd(input logic [31:0] a);
    logic [15:0] v;
    if (!mem.exists(a)) begin
      if ($urandom_range(0, 99) < 40) v = {long_ops[$urandom_range(0, 16)], 8'($urandom)};
      else v = 16'($urandom);
      mem[a] = v;
    end
    return mem[a];
  endfunction

  function automatic logic is_long_ref(input logic [15:0] op);
    logic r;
    r = 1'b0;
    foreach (long_ops[i]) if (long_ops[i] == op[15:8]) r = 1'b1;
    return r;
  endfunction

  // Next instruction of the program stream starting at model_pc.
  function automatic logic [79:0] model_fetch();
    logic [31:0] at;
    logic [15:0] op;
    logic [31:0] imm;
    at = model_pc;
    op = mem_rd(at);
    if (is_long_ref(op)) begin
      imm = {mem_rd(at + 32'd2), mem_rd(at + 32'd4)};
      model_pc = at + 32'd6;
    end else begin
      imm = 32'd0;
      model_pc = at + 32'd2;
    end
    return {at, op, imm};
  endfunction

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    return RESET_PC + 32'($urandom_range(0, 16'h3FF));
  endfunction

  // ---------------- stimulus knobs / history ----------------
  int          p_stall = 0, p_branch = 0, min_wait = 0, max_wait = 0;
  int          wait_left = 0;
  int          n_consumed = 0;
  logic        force_br = 1'b0;
  logic [31:0] force_tgt = 32'd0;
  logic        arm_br = 1'b0;
  logic [31:0] arm_tgt = 32'd0;
  logic        prev_read = 1'b0, prev_ack = 1'b0, prev_valid = 1'b0;
  logic        prev_stall = 1'b0, prev_br = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_operand = 32'd0, prev_pc = 32'd0;
  logic [15:0] prev_op = 16'd0;

  // One clock: observe at the falling edge, check, then drive the next inputs.
  task automatic tick();
    logic        st, br, ak;
    logic [31:0] tgt;
    logic [15:0] dat;
    logic [79:0] e;
    @(negedge clk_i);
    if (prev_br) check("valid_after_redirect", valid_o, 1'b0);
    else if (prev_valid && prev_stall) begin
      check("stall_valid_held", valid_o, 1'b1);
      check("stall_opcode_held", opcode_o, prev_op);
      check("stall_operand_held", operand_o, prev_operand);
      check("stall_pc_held", pc_o, prev_pc);
    end
    if (prev_read && !prev_ack) begin
      check("req_held", imem_read_o, 1'b1);
      check("addr_held", imem_address_o, prev_addr);
    end
    check("addr_even", imem_address_o[0], 1'b0);
`ifndef MOXIE_FETCH_PREFETCH_EN
    if (valid_o) check("no_req_while_present", imem_read_o, 1'b0);
`endif

    st  = ($urandom_range(0, 99) < p_stall);
    br  = ($urandom_range(0, 99) < p_branch);
    tgt = rand_target();
    if (force_br) begin br = 1'b1; tgt = force_tgt; force_br = 1'b0; end

    if (imem_read_o) begin
      if (!(prev_read && !prev_ack)) wait_left = $urandom_range(min_wait, max_wait);
      if (wait_left == 0) begin
        ak = 1'b1;
        dat = mem_rd(imem_address_o);
        rd_log.push_back(imem_address_o);
      end else begin
        ak = 1'b0;
        dat = 16'($urandom);
        wait_left--;
      end
    end else begin
      ak = ($urandom_range(0, 7) == 0);   // stray ack, must be ignored
      dat = 16'($urandom);
    end
    if (arm_br && imem_read_o && !ak) begin br = 1'b1; tgt = arm_tgt; arm_br = 1'b0; end

    if (br) begin
      exp_q.delete();
      model_pc = tgt & ~32'd1;
    end else if (valid_o && !st) begin
      if (exp_q.size() == 0) exp_q.push_back(model_fetch());
      e = exp_q.pop_front();
      check("sb_pc", pc_o, e[79:48]);
      check("sb_opcode", opcode_o, e[47:32]);
      check("sb_operand", operand_o, e[31:0]);
      n_consumed++;
    end

    stall_i = st; branch_flag_i = br; branch_target_i = tgt;
    imem_ack_i = ak; imem_data_i = dat;
    prev_read = imem_read_o; prev_ack = ak; prev_addr = imem_address_o;
    prev_valid = valid_o; prev_stall = st; prev_br = br;
    prev_op = opcode_o; prev_operand = operand_o; prev_pc = pc_o;
  endtask

  // Asynchronous reset, checked mid-cycle; a stray ack follows release.
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; branch_flag_i = 1'b0; stall_i = 1'b0; imem_ack_i = 1'b0;
    #1;
    check("rst_read", imem_read_o, 1'b0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_opcode", opcode_o, 16'd0);
    check("rst_operand", operand_o, 32'd0);
    check("rst_pc", pc_o, RESET_PC);
    check("rst_addr", imem_address_o, RESET_PC);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    imem_ack_i = 1'b1; imem_data_i = 16'hFFFF;
    model_pc = RESET_PC; exp_q.delete(); rd_log.delete(); wait_left = 0;
    prev_read = 1'b0; prev_ack = 1'b1; prev_valid = 1'b0; prev_stall = 1'b0; prev_br = 1'b0;
  endtask

  task automatic run_until_valid(input string tag);
    int n;
    n = 0;
    while (!valid_o && n < 40) begin tick(); n++; end
    check(tag, valid_o, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    int n;
    logic seen;

    // Short opcode 0x0000 at reset PC, zero-wait memory.
    mem[32'h1000] = 16'h0000;
    do_reset();
    tick();
    run_until_valid("first_valid");
    check("first_req_addr", rd_log[0], 32'h1000);
    tick();

    // Long opcode 0x0123 with immediate DEADBEEF.
    mem[32'h1000] = 16'h0123; mem[32'h1002] = 16'hDEAD; mem[32'h1004] = 16'hBEEF;
    mem[32'h1006] = 16'h2612;
    do_reset();
    tick();
    run_until_valid("long_valid");
    check("long_rd0", rd_log[0], 32'h1000);
    check("long_rd1", rd_log[1], 32'h1002);
    check("long_rd2", rd_log[2], 32'h1004);
    check("long_opcode", opcode_o, 16'h0123);
    check("long_operand", operand_o, 32'hDEADBEEF);
    check("long_pc", pc_o, 32'h1000);
    tick();
    n = 0;
    while (!imem_read_o && n < 10) begin tick(); n++; end
    check("long_next_req", imem_address_o, 32'h1006);

    // Hold five cycles under stall, then release for one consume.
    p_stall = 100;
    run_until_valid("stall_valid");
    repeat (5) tick();
    p_stall = 0;
    tick();
`ifndef MOXIE_FETCH_PREFETCH_EN
    n = 0;
    while (!imem_read_o && n < 10) begin tick(); n++; end
    check("stall_next_req", imem_address_o, model_pc);
`endif

    // Redirect to odd target while a 3-cycle read is pending.
    min_wait = 3; max_wait = 3;
    arm_br = 1'b1; arm_tgt = 32'h2001;
    n = 0;
    while (arm_br && n < 20) begin tick(); n++; end
    check("redir_armed_fired", arm_br, 1'b0);
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin
      tick(); n++;
      if (imem_read_o && imem_address_o == 32'h2000) seen = 1'b1;
      else check("redir_no_valid", valid_o, 1'b0);
    end
    check("redir_req_2000", seen, 1'b1);
    run_until_valid("redir_valid");
    tick();

    // Redirect while stalled with an instruction on display.
    min_wait = 0; max_wait = 0; p_stall = 100;
    run_until_valid("stall_redir_valid");
    force_br = 1'b1; force_tgt = 32'h1800;
    tick();
    tick();
    p_stall = 0;

    // Throughput on a run of short opcodes with zero-wait memory.
    for (int i = 0; i < 16; i++) mem[32'h3000 + 32'(2 * i)] = 16'h2612;
    force_br = 1'b1; force_tgt = 32'h3000;
    tick();
    run_until_valid("tp_first_valid");
    cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(); cnt += int'(valid_o); end
`ifdef MOXIE_FETCH_PREFETCH_EN
    check("tp_valid_count", cnt, 6);
`else
    check("tp_valid_count", cnt, 3);
`endif

    // Random traffic: latency, stalls, redirects (including wrap region).
    min_wait = 0; max_wait = 3; p_stall = 30; p_branch = 3;
    n_consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        min_wait = 4; max_wait = 4;
        n = 0;
        while (!imem_read_o && n < 20) begin tick(); n++; end
        tick();
        do_reset();
        min_wait = 0; max_wait = 3;
      end
      tick();
    end
    check("random_progress", n_consumed > 200, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
